lsu_hs: RTL and testbench

//  Handshaked, parametrised load/store unit for the RV32I pipeline MA stage. It accepts one memory request
//  on a valid/ready interface and decodes the address to data memory, output peripheral registers or

---
 rtl/lsu_hs.sv | 256 +++++++++++++++++++++++++
 tb/tb_lsu_hs.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_hs.sv
// rtl/lsu_hs.sv - handshaked load/store unit with dmem, IO registers and synchronised inputs
module lsu_hs #(
    parameter int DMEM_AW = 11,
    parameter int NUM_HEX = 8,
    parameter int LEDR_W  = 17,
    parameter int LEDG_W  = 8,
    parameter int SW_W    = 18,
    parameter int BTN_W   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [2:0]           i_funct3,
    input  logic [31:0]          i_addr,
    input  logic [31:0]          i_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rdata,
    output logic                 o_err,
    input  logic [SW_W-1:0]      i_io_sw,
    input  logic [BTN_W-1:0]     i_io_btn,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd
);

    localparam int          DMEM_WORDS = 2 ** (DMEM_AW - 2);
    localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
    localparam logic [32:0] DMEM_SPAN  = 33'd1 << DMEM_AW;

    // Word addresses (byte address >> 2) of the IO registers and inputs
    localparam logic [29:0] WA_LEDR = 30'h1C00;
    localparam logic [29:0] WA_LEDG = 30'h1C04;
    localparam logic [29:0] WA_HEX  = 30'h1C08;
    localparam logic [29:0] WA_LCD  = 30'h1C10;
    localparam logic [29:0] WA_SW   = 30'h1E00;
    localparam logic [29:0] WA_BTN  = 30'h1E04;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t             state;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               err_q;
    logic               rd_io_q;
    logic [31:0]        io_rd_q;
    logic [31:0]        mem_rd_q;

    logic [LEDR_W-1:0]  ledr_q;
    logic [LEDG_W-1:0]  ledg_q;
    logic [6:0]         hex_q [NUM_HEX];
    logic [31:0]        lcd_q;
    logic [SW_W-1:0]    sw_meta, sw_sync;
    logic [BTN_W-1:0]   btn_meta, btn_sync;

    logic [31:0]        mem [DMEM_WORDS];

    // Address decode of the latched request
    logic [29:0]        waddr;
    logic [31:0]        dmem_off;
    logic [DMEM_AW-3:0] dmem_idx;
    logic [2:0]         hex_idx;
    logic               hit_dmem, hit_ledr, hit_ledg, hit_hex, hit_lcd, hit_sw, hit_btn;
    logic               f3_legal, misaligned, acc_err, do_store;
    logic [1:0]         size;
    logic [3:0]         st_be;
    logic [31:0]        st_data, st_mask, io_word, merged;

    assign waddr    = addr_q[31:2];
    assign dmem_off = addr_q - DMEM_BASE;
    assign dmem_idx = dmem_off[DMEM_AW-1:2];
    assign hex_idx  = addr_q[4:2];
    assign size     = f3_q[1:0];

    // Region hits, funct3 legality, alignment and the combined error
    always_comb begin
        hit_dmem   = (addr_q >= DMEM_BASE) && ({1'b0, dmem_off} < DMEM_SPAN);
        hit_ledr   = (waddr == WA_LEDR);
        hit_ledg   = (waddr == WA_LEDG);
        hit_hex    = (waddr >= WA_HEX) && (waddr < WA_HEX + 30'(NUM_HEX));
        hit_lcd    = (waddr == WA_LCD);
        hit_sw     = (waddr == WA_SW);
        hit_btn    = (waddr == WA_BTN);
        if (we_q)
            f3_legal = !f3_q[2] && (size != 2'b11);
        else
            f3_legal = (size != 2'b11) && !(f3_q[2] && size == 2'b10);
        misaligned = (size == 2'b01 && addr_q[0]) || (size == 2'b10 && addr_q[1:0] != 2'b00);
        acc_err    = !f3_legal || misaligned
                   || !(hit_dmem || hit_ledr || hit_ledg || hit_hex || hit_lcd || hit_sw || hit_btn)
                   || (we_q && (hit_sw || hit_btn));
        do_store   = (state == S_ACCESS) && we_q && !acc_err;
    end

    // Store lane replication and byte enables
    always_comb begin
        st_be   = 4'b1111;
        st_data = wdata_q;
        case (size)
            2'b00: begin
                st_be   = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata_q;
            end
        endcase
        st_mask = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};
    end

    // Selected IO register or input, zero-extended; also the base for sub-word merges
    always_comb begin
        io_word = '0;
        if (hit_ledr) io_word = 32'(ledr_q);
        if (hit_ledg) io_word = 32'(ledg_q);
        if (hit_hex)  io_word = 32'(hex_q[hex_idx]);
        if (hit_lcd)  io_word = lcd_q;
        if (hit_sw)   io_word = 32'(sw_sync);
        if (hit_btn)  io_word = 32'(btn_sync);
        merged = (io_word & ~st_mask) | (st_data & st_mask);
    end

    // Request/response FSM with registered handshake outputs and IO register writes
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rd_io_q     <= 1'b0;
            io_rd_q     <= '0;
            ledr_q      <= '0;
            ledg_q      <= '0;
            lcd_q       <= '0;
            for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        we_q        <= i_req_we;
                        f3_q        <= i_funct3;
                        addr_q      <= i_addr;
                        wdata_q     <= i_wdata;
                        req_ready_q <= 1'b0;
                        state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rsp_valid_q <= 1'b1;
                    err_q       <= acc_err;
                    rd_io_q     <= !hit_dmem;
                    io_rd_q     <= io_word;
                    if (do_store) begin
                        if (hit_ledr) ledr_q <= merged[LEDR_W-1:0];
                        if (hit_ledg) ledg_q <= merged[LEDG_W-1:0];
                        if (hit_hex)  hex_q[hex_idx] <= merged[6:0];
                        if (hit_lcd)  lcd_q <= merged;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    // Data memory: byte-enabled write and synchronous read, both issued in ACCESS
    always_ff @(posedge i_clk) begin
        if (state == S_ACCESS) begin
            if (do_store && hit_dmem) begin
                for (int i = 0; i < 4; i++)
                    if (st_be[i]) mem[dmem_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
            mem_rd_q <= mem[dmem_idx];
        end
    end

    // Two-flop synchronisers for the asynchronous switch and button inputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= i_io_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_io_btn;
            btn_sync <= btn_meta;
        end
    end

    // Load formatting: lane select and extension, forced to 0 outside a good load response
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_fmt;
    always_comb begin
        rd_word = rd_io_q ? io_rd_q : mem_rd_q;
        rd_byte = 8'(rd_word >> {addr_q[1:0], 3'b000});
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (f3_q)
            3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
            3'b010:  rd_fmt = rd_word;
            3'b100:  rd_fmt = {24'b0, rd_byte};
            3'b101:  rd_fmt = {16'b0, rd_half};
            default: rd_fmt = '0;
        endcase
        o_rdata = (rsp_valid_q && !err_q && !we_q) ? rd_fmt : '0;
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_err       = err_q;
    assign o_io_ledr   = ledr_q;
    assign o_io_ledg   = ledg_q;
    assign o_io_lcd    = lcd_q;

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        assign o_io_hex[7*k +: 7] = hex_q[k];
    end

endmodule

// File: tb/tb_lsu_hs.sv
// tb/tb_lsu_hs.sv - scoreboard bench for lsu_hs
module tb_lsu_hs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rdata;
    logic        err;
    logic [17:0] io_sw;
    logic [3:0]  io_btn;
    logic [16:0] io_ledr;
    logic [7:0]  io_ledg;
    logic [55:0] io_hex;
    logic [31:0] io_lcd;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    always #5 clk = ~clk;

    lsu_hs dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rdata     (rdata),
        .o_err       (err),
        .i_io_sw     (io_sw),
        .i_io_btn    (io_btn),
        .o_io_ledr   (io_ledr),
        .o_io_ledg   (io_ledg),
        .o_io_hex    (io_hex),
        .o_io_lcd    (io_lcd)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per consumed response
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {31'b0, err, rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", {31'b0, err, rdata}, {31'b0, e.err, e.rdata});
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        req_valid = 1'b1;
        exp_q.push_back('{rdata: er, err: ee});
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("access_ready_valid", {62'b0, req_ready, rsp_valid}, 64'd0);
        @(posedge clk);
        #1 chk("latency_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((!req_ready || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] hex_exp;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        rsp_ready = 1'b1; io_sw = '0; io_btn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_rdata_err", {31'b0, err, rdata}, 64'd0);
        chk("rst_io", {io_lcd, 15'b0, io_ledr}, 64'd0);
        chk("rst_hex_ledg", {io_ledg, io_hex}, 64'd0);

        // dmem word, byte and half accesses
        do_req(1, F_W,  32'h2004, 32'hDEADBEEF, 32'h0, 0);
        do_req(0, F_W,  32'h2004, 32'h0, 32'hDEADBEEF, 0);
        do_req(1, F_B,  32'h2005, 32'h80, 32'h0, 0);
        do_req(0, F_B,  32'h2005, 32'h0, 32'hFFFFFF80, 0);
        do_req(0, F_BU, 32'h2005, 32'h0, 32'h00000080, 0);
        do_req(0, F_W,  32'h2004, 32'h0, 32'hDEAD80EF, 0);
        do_req(0, F_H,  32'h2006, 32'h0, 32'hFFFFDEAD, 0);
        do_req(0, F_HU, 32'h2006, 32'h0, 32'h0000DEAD, 0);

        // errors and boundaries
        do_req(1, F_W,  32'h2000, 32'h01234567, 32'h0, 0);
        do_req(0, F_H,  32'h2003, 32'h0, 32'h0, 1);
        do_req(1, F_W,  32'h2002, 32'h55555555, 32'h0, 1);
        do_req(0, F_W,  32'h2000, 32'h0, 32'h01234567, 0);
        do_req(0, F_W,  32'h2004, 32'h0, 32'hDEAD80EF, 0);
        do_req(0, F_W,  32'h5000, 32'h0, 32'h0, 1);
        do_req(0, 3'b011, 32'h2004, 32'h0, 32'h0, 1);
        do_req(1, 3'b100, 32'h2004, 32'h0, 32'h0, 1);
        do_req(1, F_W,  32'h27FC, 32'hCAFEF00D, 32'h0, 0);
        do_req(0, F_W,  32'h27FC, 32'h0, 32'hCAFEF00D, 0);
        do_req(0, F_W,  32'h2800, 32'h0, 32'h0, 1);
        do_req(0, F_W,  32'h1FFC, 32'h0, 32'h0, 1);

        // synchronised inputs
        wait_idle();
        io_sw  = 18'h2A5A5;
        io_btn = 4'hA;
        repeat (3) @(posedge clk);
        do_req(0, F_W,  32'h7800, 32'h0, 32'h0002A5A5, 0);
        do_req(0, F_B,  32'h7800, 32'h0, 32'hFFFFFFA5, 0);
        do_req(1, F_W,  32'h7800, 32'h1, 32'h0, 1);
        do_req(0, F_W,  32'h7810, 32'h0, 32'h0000000A, 0);
        do_req(1, F_B,  32'h7810, 32'h1, 32'h0, 1);

        // IO registers
        do_req(1, F_W,  32'h7000, 32'hFFFFFFFF, 32'h0, 0);
        wait_idle();
        chk("ledr", {47'b0, io_ledr}, 64'h1FFFF);
        do_req(0, F_W,  32'h7000, 32'h0, 32'h0001FFFF, 0);
        do_req(0, F_B,  32'h7001, 32'h0, 32'hFFFFFFFF, 0);
        do_req(0, F_BU, 32'h7002, 32'h0, 32'h00000001, 0);
        do_req(1, F_B,  32'h7024, 32'h7F, 32'h0, 0);
        do_req(1, F_W,  32'h703C, 32'h5, 32'h0, 0);
        do_req(1, F_B,  32'h7044, 32'h1, 32'h0, 1);
        wait_idle();
        hex_exp = (56'h7F << 7) | (56'h5 << 49);
        chk("hex", {8'b0, io_hex}, {8'b0, hex_exp});
        do_req(0, F_BU, 32'h7024, 32'h0, 32'h0000007F, 0);
        do_req(1, F_W,  32'h7010, 32'h00001234, 32'h0, 0);
        do_req(1, F_B,  32'h7011, 32'h000000AB, 32'h0, 0);
        do_req(1, F_H,  32'h7042, 32'h0000BEEF, 32'h0, 0);
        wait_idle();
        chk("ledg", {56'b0, io_ledg}, 64'h34);
        chk("lcd", {32'b0, io_lcd}, 64'hBEEF0000);
        do_req(0, F_H,  32'h7042, 32'h0, 32'hFFFFBEEF, 0);

        // back-pressure
        wait_idle();
        rsp_ready = 1'b0;
        do_req(0, F_W, 32'h2004, 32'h0, 32'hDEAD80EF, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_ready", {62'b0, rsp_valid, req_ready}, 64'd2);
            chk("bp_rdata", {31'b0, err, rdata}, {32'b0, 32'hDEAD80EF});
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle();

        // reset during ACCESS of a store
        do_req(1, F_W, 32'h2008, 32'h11111111, 32'h0, 0);
        wait_idle();
        @(negedge clk);
        req_we = 1'b1; funct3 = F_W; addr = 32'h2008; wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rst_mid_access", {63'b0, req_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp", {30'b0, rsp_valid, err, rdata}, 64'd0);
        chk("rst_mid_io", {io_lcd, 15'b0, io_ledr}, 64'd0);
        chk("rst_mid_hex", {io_ledg, io_hex}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_idle", {62'b0, rsp_valid, req_ready}, 64'd1);
        do_req(0, F_W, 32'h2008, 32'h0, 32'h11111111, 0);

        wait_idle();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
